// File: rtl/data_mem_lsu.sv
// Load/store unit driving a word-wide, big-endian DataMem port.
// Sub-word stores are read-modify-write; every output is driven from a register.
module data_mem_lsu #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       WriteData,
    output logic [1:0]        MemWrite,
    output logic [1:0]        MemRead,
    input  logic [31:0]       ReadData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsuState_t;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    function automatic logic [31:0] extractLoad(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  offset,
        input logic        isSigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = 8'h00;
        res = 32'h0000_0000;
        case (offset)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        h = offset[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: res = {{24{isSigned & b[7]}}, b};
            SZ_HALF: res = {{16{isSigned & h[15]}}, h};
            SZ_WORD: res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] mergeStore(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  offset,
        input logic [31:0] wdata
    );
        logic [31:0] res;
        res = word;
        if (size == SZ_BYTE) begin
            case (offset)
                2'd0:    res[31:24] = wdata[7:0];
                2'd1:    res[23:16] = wdata[7:0];
                2'd2:    res[15:8]  = wdata[7:0];
                2'd3:    res[7:0]   = wdata[7:0];
                default: res        = word;
            endcase
        end else if (size == SZ_HALF) begin
            if (offset[1]) begin
                res[15:0] = wdata[15:0];
            end else begin
                res[31:16] = wdata[15:0];
            end
        end else begin
            res = wdata;
        end
        return res;
    endfunction

    lsuState_t         state_r, nextState_s;
    logic              pending_r, nextPending_s;
    logic [1:0]        cnt_r, nextCnt_s;
    logic [ADDR_W-1:0] reqAddr_r, nextAddr_s;
    logic [1:0]        reqSize_r, nextSize_s;
    logic              reqSigned_r, nextSigned_s;
    logic              reqWrite_r, nextWrite_s;
    logic [31:0]       reqWdata_r, nextWdata_s;
    logic [31:0]       word_r, nextWord_s;
    logic [31:0]       rspRdata_r, nextRdata_s;
    logic              rspErr_r, nextErr_s;
    logic              reqReady_r, nextReqReady_s;
    logic              rspValid_r, nextRspValid_s;
    logic [ADDR_W-1:0] address_r, nextAddress_s;
    logic [31:0]       writeData_r, nextWriteData_s;
    logic [1:0]        memWrite_r, nextMemWrite_s;
    logic [1:0]        memRead_r, nextMemRead_s;
    logic              illegal_s;

    // Misalignment and size legality of the latched request.
    always_comb begin
        illegal_s = 1'b0;
        case (reqSize_r)
            SZ_BYTE: illegal_s = 1'b0;
            SZ_HALF: illegal_s = reqAddr_r[0];
            SZ_WORD: illegal_s = (reqAddr_r[1:0] != 2'b00);
            default: illegal_s = 1'b1;
        endcase
    end

    // Next-state logic; outputs are derived from the next state so they register in step with it.
    always_comb begin
        nextState_s   = state_r;
        nextPending_s = pending_r;
        nextCnt_s     = cnt_r;
        nextAddr_s    = reqAddr_r;
        nextSize_s    = reqSize_r;
        nextSigned_s  = reqSigned_r;
        nextWrite_s   = reqWrite_r;
        nextWdata_s   = reqWdata_r;
        nextWord_s    = word_r;
        nextRdata_s   = rspRdata_r;
        nextErr_s     = rspErr_r;
        case (state_r)
            IDLE: begin
                if (pending_r) begin
                    // Decode cycle: the request was latched on the previous edge.
                    nextPending_s = 1'b0;
                    nextCnt_s     = 2'd0;
                    if (illegal_s) begin
                        nextState_s = RESP;
                        nextErr_s   = 1'b1;
                        nextRdata_s = 32'h0000_0000;
                    end else if (!reqWrite_r || (reqSize_r != SZ_WORD)) begin
                        nextState_s = RD;
                    end else begin
                        nextState_s = WR;
                        nextWord_s  = reqWdata_r;
                    end
                end else if (req_valid) begin
                    nextPending_s = 1'b1;
                    nextAddr_s    = req_addr;
                    nextSize_s    = req_size;
                    nextSigned_s  = req_signed;
                    nextWrite_s   = req_write;
                    nextWdata_s   = req_wdata;
                end else begin
                    nextPending_s = 1'b0;
                end
            end
            RD: begin
                if (cnt_r == CNT_LAST) begin
                    nextCnt_s = 2'd0;
                    if (reqWrite_r) begin
                        nextState_s = WR;
                        nextWord_s  = mergeStore(ReadData, reqSize_r, reqAddr_r[1:0], reqWdata_r);
                    end else begin
                        nextState_s = RESP;
                        nextRdata_s = extractLoad(ReadData, reqSize_r, reqAddr_r[1:0], reqSigned_r);
                        nextErr_s   = 1'b0;
                    end
                end else begin
                    nextCnt_s = cnt_r + 2'd1;
                end
            end
            WR: begin
                nextState_s = RESP;
                nextRdata_s = 32'h0000_0000;
                nextErr_s   = 1'b0;
            end
            RESP: begin
                if (rsp_ready) begin
                    nextState_s = IDLE;
                    nextRdata_s = 32'h0000_0000;
                    nextErr_s   = 1'b0;
                end else begin
                    nextState_s = RESP;
                end
            end
            default: begin
                nextState_s   = IDLE;
                nextPending_s = 1'b0;
                nextCnt_s     = 2'd0;
                nextRdata_s   = 32'h0000_0000;
                nextErr_s     = 1'b0;
            end
        endcase

        nextReqReady_s  = (nextState_s == IDLE) && !nextPending_s;
        nextRspValid_s  = (nextState_s == RESP);
        nextMemRead_s   = (nextState_s == RD) ? 2'b01 : 2'b00;
        nextMemWrite_s  = (nextState_s == WR) ? 2'b01 : 2'b00;
        nextWriteData_s = (nextState_s == WR) ? nextWord_s : 32'h0000_0000;
        if ((nextState_s == RD) || (nextState_s == WR)) begin
            nextAddress_s = {nextAddr_s[ADDR_W-1:2], 2'b00};
        end else begin
            nextAddress_s = '0;
        end
    end

    // State, request latch and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pending_r   <= 1'b0;
            cnt_r       <= 2'd0;
            reqAddr_r   <= '0;
            reqSize_r   <= 2'd0;
            reqSigned_r <= 1'b0;
            reqWrite_r  <= 1'b0;
            reqWdata_r  <= 32'h0000_0000;
            word_r      <= 32'h0000_0000;
            rspRdata_r  <= 32'h0000_0000;
            rspErr_r    <= 1'b0;
            reqReady_r  <= 1'b1;
            rspValid_r  <= 1'b0;
            address_r   <= '0;
            writeData_r <= 32'h0000_0000;
            memWrite_r  <= 2'b00;
            memRead_r   <= 2'b00;
        end else begin
            state_r     <= nextState_s;
            pending_r   <= nextPending_s;
            cnt_r       <= nextCnt_s;
            reqAddr_r   <= nextAddr_s;
            reqSize_r   <= nextSize_s;
            reqSigned_r <= nextSigned_s;
            reqWrite_r  <= nextWrite_s;
            reqWdata_r  <= nextWdata_s;
            word_r      <= nextWord_s;
            rspRdata_r  <= nextRdata_s;
            rspErr_r    <= nextErr_s;
            reqReady_r  <= nextReqReady_s;
            rspValid_r  <= nextRspValid_s;
            address_r   <= nextAddress_s;
            writeData_r <= nextWriteData_s;
            memWrite_r  <= nextMemWrite_s;
            memRead_r   <= nextMemRead_s;
        end
    end

    assign req_ready = reqReady_r;
    assign rsp_valid = rspValid_r;
    assign rsp_rdata = rspRdata_r;
    assign rsp_err   = rspErr_r;
    assign Address   = address_r;
    assign WriteData = writeData_r;
    assign MemWrite  = memWrite_r;
    assign MemRead   = memRead_r;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed plus random bench for data_mem_lsu against a byte-array reference memory.
module tb_data_mem_lsu;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [1:0]  MemWrite;
    logic [1:0]  MemRead;
    logic [31:0] ReadData;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];
    logic [7:0]  refMem [0:255];
    bit          memInit = 1'b0;
    int          rdCyc = 0;
    int          wrCyc = 0;
    int          bothCyc = 0;
    logic [31:0] lastWrAddr = 32'h0;
    logic [31:0] lastWrData = 32'h0;
    logic [31:0] lastRdata = 32'h0;

    data_mem_lsu #(.RD_LAT(RD_LAT), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .Address(Address),
        .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
        .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int i);
        logic [31:0] v;
        v = 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
        if (i == 5) v = 32'h5555_5555;
        else if (i == 10) v = 32'hAAAA_AAAA;
        return v;
    endfunction

    function automatic logic [31:0] refWord(input logic [7:0] ab);
        logic [7:0] wa;
        wa = {ab[7:2], 2'b00};
        return {refMem[wa], refMem[wa + 8'd1], refMem[wa + 8'd2], refMem[wa + 8'd3]};
    endfunction

    assign ReadData = mem[Address[7:2]];

    // DataMem model plus activity monitor.
    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
            memInit <= 1'b1;
        end else if (MemWrite == 2'b01) begin
            mem[Address[7:2]] <= WriteData;
        end
        if (MemWrite == 2'b01) begin
            wrCyc      <= wrCyc + 1;
            lastWrAddr <= Address;
            lastWrData <= WriteData;
        end
        if (MemRead == 2'b01) rdCyc <= rdCyc + 1;
        if (MemWrite == 2'b01 && MemRead == 2'b01) bothCyc <= bothCyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic [7:0]  ab;
        logic        bad;
        logic [31:0] expData;
        logic [31:0] expWord;
        int          expLat, expRd, expWr, lat, rd0, wr0;
        ab      = a[7:0];
        bad     = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        expData = 32'h0;
        expWord = 32'h0;
        if (bad) begin
            expLat = 1; expRd = 0; expWr = 0;
        end else if (!w) begin
            if (sz == 2'd0) begin
                expData = {24'h0, refMem[ab]};
                if (sg && refMem[ab][7]) expData[31:8] = 24'hFF_FFFF;
            end else if (sz == 2'd1) begin
                expData = {16'h0, refMem[ab], refMem[ab + 8'd1]};
                if (sg && refMem[ab][7]) expData[31:16] = 16'hFFFF;
            end else begin
                expData = refWord(ab);
            end
            expLat = 1 + RD_LAT; expRd = RD_LAT; expWr = 0;
        end else begin
            if (sz == 2'd0) begin
                refMem[ab] = wd[7:0];
            end else if (sz == 2'd1) begin
                refMem[ab]        = wd[15:8];
                refMem[ab + 8'd1] = wd[7:0];
            end else begin
                for (int k = 0; k < 4; k++) refMem[ab + 8'(k)] = wd[31 - 8 * k -: 8];
            end
            expWord = refWord(ab);
            expLat  = (sz == 2'd2) ? 2 : 2 + RD_LAT;
            expRd   = (sz == 2'd2) ? 0 : RD_LAT;
            expWr   = 1;
        end

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'h1);
        rd0 = rdCyc; wr0 = wrCyc;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(expLat));
        check("rsp_rdata", rsp_rdata, expData);
        check("rsp_err", 32'(rsp_err), 32'(bad));
        lastRdata = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'($urandom_range(0, 1));
            req_size = 2'($urandom_range(0, 2)); req_addr = 32'($urandom_range(0, 255)) & 32'hFC;
            req_wdata = $urandom;
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'h1);
            check("hold_rdata", rsp_rdata, expData);
            check("hold_err", 32'(rsp_err), 32'(bad));
            check("hold_ready", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'h0);
        check("ready_back", 32'(req_ready), 32'h1);
        check("read_cycles", 32'(rdCyc - rd0), 32'(expRd));
        check("write_cycles", 32'(wrCyc - wr0), 32'(expWr));
        if (expWr == 1) begin
            check("write_addr", lastWrAddr, {a[31:2], 2'b00});
            check("write_data", lastWrData, expWord);
        end
        check("rd_wr_exclusive", 32'(bothCyc), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rsz;
        logic [31:0] ra;
        int          wr0, waitCnt;

        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) refMem[4 * i + k] = initWord(i) >> (24 - 8 * k);
        end
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_address", Address, 32'h0);
        check("rst_writedata", WriteData, 32'h0);
        check("rst_memwrite", 32'(MemWrite), 32'h0);
        check("rst_memread", 32'(MemRead), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        doReq(1'b0, 2'd2, 1'b0, 32'h28, 32'h0, 5);
        check("plan_word_load", lastRdata, 32'hAAAA_AAAA);
        doReq(1'b0, 2'd0, 1'b1, 32'h29, 32'h0, 0);
        check("plan_byte_signed", lastRdata, 32'hFFFF_FFAA);
        doReq(1'b0, 2'd0, 1'b0, 32'h29, 32'h0, 0);
        check("plan_byte_unsigned", lastRdata, 32'h0000_00AA);
        doReq(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 0);
        check("plan_half_signed", lastRdata, 32'h0000_5555);
        doReq(1'b1, 2'd0, 1'b0, 32'h15, 32'h99, 0);
        check("plan_byte_store_addr", lastWrAddr, 32'h14);
        check("plan_byte_store_data", lastWrData, 32'h5599_5555);
        doReq(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
        check("plan_reload", lastRdata, 32'h5599_5555);
        doReq(1'b1, 2'd2, 1'b0, 32'h28, 32'hEEEE_EEEE, 0);
        check("plan_word_store_data", lastWrData, 32'hEEEE_EEEE);
        doReq(1'b0, 2'd1, 1'b0, 32'h15, 32'h0, 0);
        doReq(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 0);
        doReq(1'b1, 2'd1, 1'b1, 32'h8000_0036, 32'h1234_ABCD, 0);

        for (int n = 0; n < 150; n++) begin
            rsz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra[31:8] = 24'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'd1) ra[0] = 1'b0;
                else if (rsz == 2'd2) ra[1:0] = 2'b00;
            end
            doReq(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom,
                  (n % 10 == 0) ? 2 : 0);
        end

        // Reset in the read phase of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h15; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waitCnt = 0;
        while (MemRead !== 2'b01 && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        check("rst_mid_read_seen", 32'(MemRead), 32'h1);
        wr0 = wrCyc;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'h1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_rsp_err", 32'(rsp_err), 32'h0);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
        check("mid_rst_address", Address, 32'h0);
        check("mid_rst_writedata", WriteData, 32'h0);
        check("mid_rst_memwrite", 32'(MemWrite), 32'h0);
        check("mid_rst_memread", 32'(MemRead), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_no_write", 32'(wrCyc - wr0), 32'h0);
        check("mid_rst_mem_0x14", mem[5], refWord(8'h14));
        doReq(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store initiator that drives the DataMem port: Address, WriteData, MemWrite, MemRead and ReadData.
- Accepts one byte, halfword or word request at a time from the CPU datapath over a valid/ready handshake.
- Performs aligned word accesses to DataMem and extracts loaded data, with optional sign extension.
- DataMem writes only whole words, so sub-word stores use read-modify-write.

Parameters:
- RD_LAT, 1: cycles MemRead and Address are held before ReadData is sampled (1..4).
- ADDR_W, 32: width of the request address and Address output.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal (flagged as an error)
- req_signed  in  1  sign-extend loads
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal size
- Address  out  ADDR_W  word-aligned address to DataMem
- WriteData  out  32  word to DataMem
- MemWrite  out  2  2'b01 = write this cycle, else 2'b00
- MemRead  out  2  2'b01 = read, else 2'b00
- ReadData  in  32  word from DataMem

Behaviour:
- Memory contract: big-endian. The byte at word offset 0 maps to bits [31:24] and offset 3 to bits [7:0]. DataMem writes on the rising clk edge while MemWrite = 01.
- Reset (rst_n low, asynchronous): state goes to IDLE.
  - req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - Address = 0, WriteData = 0, MemWrite = 00, MemRead = 00.
  - The internal RD_LAT counter is cleared.
- Reset mid-operation: abandons the request with no memory write issued afterwards. A write already committed on an earlier edge stays.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready = 1; a request is accepted on an edge where req_valid = 1.
  - The LSU latches addr, size, signed, write and wdata.
  - Misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or size = 3 -> RESP with err = 1. No memory access is made.
  - Aligned load -> RD.
  - Aligned word store -> WR.
  - Aligned byte or half store -> RD, then WR.
- RD:
  - Address = {addr[ADDR_W-1:2], 2'b00}, MemRead = 01.
  - The state is held RD_LAT cycles; ReadData is sampled on the last edge.
  - Load -> RESP with extracted data. Sub-word store -> WR with the merged word.
- WR:
  - Exactly one cycle: Address is word-aligned, WriteData is the full or merged word, MemWrite = 01, MemRead = 00.
  - Then -> RESP with rdata = 0.
- RESP:
  - rsp_valid = 1 and outputs are held stable until an edge with rsp_ready = 1, then -> IDLE.
  - req_ready = 0 in every state except IDLE (single outstanding request).
- Extraction:
  - Byte offset k selects ReadData[31-8k -: 8].
  - Half offset 0 selects [31:16]; offset 2 selects [15:0].
  - req_signed = 1 replicates the MSB of the extracted field; req_signed = 0 zero-fills.
- Merge: only the addressed byte or half lane is replaced from req_wdata[7:0] or req_wdata[15:0]; the other lanes keep the sampled ReadData.
- MemWrite and MemRead are never both 01 in the same cycle. Both are 00 in IDLE and RESP.
- Latency with RD_LAT = 1, accept edge = 0:
  - Load: rsp_valid from edge 2.
  - Word store: rsp_valid from edge 2.
  - Sub-word store: rsp_valid from edge 3.
  - Error: rsp_valid from edge 1.
- Addresses above the DataMem range are passed through unchanged; no range check.

Test Plan:
- Preload words 0x14 = 0x55555555 and 0x28 = 0xAAAAAAAA. Word load at 0x28 -> rsp_rdata 0xAAAAAAAA, err 0, rsp_valid 2 cycles after accept.
- Byte load at 0x29, signed -> 0xFFFFFFAA; same load unsigned -> 0x000000AA. Half load at 0x16, signed -> 0x00005555.
- Byte store 0x99 at 0x15 -> exactly one MemWrite = 01 cycle with Address 0x14 and WriteData 0x55995555; a following word load at 0x14 returns 0x55995555.
- Word store 0xEEEEEEEE at 0x28 -> one write cycle, no MemRead. Half load at 0x15, and size = 3 at 0x00 -> rsp_err 1, rsp_rdata 0, MemRead and MemWrite stay 00.
- Hold rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready 0, new req_valid ignored.
- Assert rst_n = 0 during RD of a byte store -> all outputs reach reset values immediately. No MemWrite pulse follows, and memory at 0x14 is unchanged.
